peripheral_msi_slave_port_apb4: RTL and testbench
=================================================

Name: peripheral_msi_slave_port_apb4

Overview:
- Per-slave arbitration and multiplexing stage of the Master Slave Interface (MSI) interconnect.
- Sits directly downstream of the MSI master ports. Each master port drives one request lane here (slvHSEL bit, address-phase signals, slvpriority, can_switch). This block returns one master_granted bit per master port.
- Selects one owning master by priority, with round-robin among equal priorities, and forwards its address phase to a single AHB-Lite slave.
- Tracks the data-phase owner separately so HWDATA is routed correctly across master switches.

Parameters:
- PLEN, 64, address width
- XLEN, 64, data width
- MASTERS, 5, number of master ports (request lanes); MASTERS_BITS = $clog2(MASTERS), minimum 1

Ports:
- HCLK  in  1  clock, all state on rising edge
- HRESET  in  1  synchronous, active-high reset
- mst_priority  in  [MASTERS][3]  per-lane priority, higher value wins
- mst_HSEL  in  [MASTERS]  per-lane request (the master port's slvHSEL bit for this slave)
- mst_HADDR  in  [MASTERS][PLEN]  per-lane address
- mst_HWDATA  in  [MASTERS][XLEN]  per-lane write data
- mst_HWRITE  in  [MASTERS]  per-lane write
- mst_HSIZE  in  [MASTERS][3]  per-lane size
- mst_HBURST  in  [MASTERS][3]  per-lane burst
- mst_HPROT  in  [MASTERS][4]  per-lane protection
- mst_HTRANS  in  [MASTERS][2]  per-lane transfer type
- mst_HMASTLOCK  in  [MASTERS]  per-lane lock
- mst_HREADY  in  [MASTERS]  per-lane HREADY from the master port (its slvHREADYOUT)
- mst_can_switch  in  [MASTERS]  per-lane switch permission
- master_granted  out  [MASTERS]  one-hot grant, registered
- mst_HRDATA  out  XLEN  read data to all lanes
- mst_HREADYOUT  out  1  slave HREADYOUT forwarded to all lanes
- mst_HRESP  out  1  slave HRESP forwarded to all lanes
- slv_HSEL  out  1  slave select
- slv_HADDR  out  PLEN  slave address
- slv_HWDATA  out  XLEN  slave write data
- slv_HWRITE  out  1  slave write
- slv_HSIZE  out  3  slave size
- slv_HBURST  out  3  slave burst
- slv_HPROT  out  4  slave protection
- slv_HTRANS  out  2  slave transfer type
- slv_HMASTLOCK  out  1  slave lock
- slv_HREADY  out  1  slave HREADY input
- slv_HRDATA  in  XLEN  slave read data
- slv_HREADYOUT  in  1  slave ready
- slv_HRESP  in  1  slave response

Behaviour:
- State registers:
  - owner_valid, owner (MASTERS_BITS)
  - data_valid, data_owner (MASTERS_BITS)
  - last_grant (MASTERS_BITS), the round-robin pointer
- Reset (HRESET=1 at a clock edge):
  - owner_valid=0, data_valid=0, last_grant=MASTERS-1
  - master_granted=0, slv_HSEL=0, slv_HTRANS=IDLE(2'b00), slv_HREADY=1, mst_HREADYOUT=1, mst_HRESP=OKAY
  - Reset mid-transfer aborts the ownership record without handshake.
- Winner selection (combinational):
  - Only lanes with mst_HSEL=1 are candidates.
  - The winner has the maximum mst_priority among candidates.
  - Ties go to the first tied lane scanning upward from last_grant+1, wrapping modulo MASTERS.
- Re-arbitration enable, arb_en:
  - (owner_valid=0), or
  - (mst_can_switch[owner]=1 AND mst_HMASTLOCK[owner]=0 AND slv_HREADYOUT=1).
- On a clock edge with arb_en=1:
  - If any candidate exists: owner<=winner, owner_valid<=1, last_grant<=winner.
  - If there is no candidate: owner_valid<=0 and last_grant is held.
- On a clock edge with arb_en=0: owner is held.
- The owner may be re-granted to itself; this costs no idle cycle.
- master_granted = owner_valid ? onehot(owner) : 0.
  - Request-to-grant latency is 1 cycle, so a newly requesting master port passes through its pending state.
- Address phase (combinational mux by owner):
  - slv_HSEL = owner_valid & mst_HSEL[owner].
  - slv_HTRANS = slv_HSEL ? mst_HTRANS[owner] : IDLE.
  - All other slv_* address signals come from the owner lane, or are 0 when owner_valid=0.
  - slv_HREADY = owner_valid ? mst_HREADY[owner] : 1.
- Data phase:
  - When slv_HREADYOUT=1 AND slv_HREADY=1: data_valid <= (slv_HSEL & slv_HTRANS ∈ {NONSEQ, SEQ}) and data_owner <= owner.
  - slv_HWDATA = mst_HWDATA[data_owner].
- Return path:
  - mst_HRDATA = slv_HRDATA.
  - mst_HREADYOUT = slv_HREADYOUT.
  - mst_HRESP = data_valid ? slv_HRESP : OKAY.
- Switch boundary: ownership changes only on a cycle where the slave is ready. The outgoing owner's last data phase and the incoming owner's first address phase overlap; HWDATA follows data_owner, not owner.
- Simultaneous events:
  - The owner dropping HSEL while another lane requests is a normal switch. It is ignored while the owner asserts HMASTLOCK.
  - Equal priority under continuous requests: grants rotate in strict index order with no starvation.
- Slave wait states (slv_HREADYOUT=0): owner, data_owner and all muxes are frozen.

Test Plan:
- Single request, lane 2, priority 1, at cycle 0 -> master_granted=5'b00100 at cycle 1. slv_HSEL=1 and slv_HADDR=lane 2 address from cycle 1.
- Lanes 0 and 3 request together, priorities 2 and 5 -> lane 3 is granted. After lane 3 asserts can_switch with slave ready, lane 0 is granted on the next cycle.
- Lanes 1, 2, 4 at equal priority, all continuously requesting with can_switch=1, starting from reset -> grant order 1, 2, 4, 1, 2, 4.
- Owner lane 1 with HMASTLOCK=1 and can_switch=1, lane 0 at higher priority requesting -> lane 1 keeps the grant until HMASTLOCK=0.
- Write from lane 0, then switch to lane 3 with slave HREADYOUT low for 2 cycles -> grant and muxes frozen for 2 cycles. slv_HWDATA = lane 0 data during lane 0's data phase, even after master_granted=5'b01000.
- HRESET pulsed during a lane 2 burst -> next cycle master_granted=0, slv_HTRANS=IDLE, mst_HRESP=OKAY. Tie order restarts at lane 0.

Source files
------------

// File: rtl/peripheral_msi_slave_port_apb4_if.sv
// Bus bundle between the MSI master ports, the per-slave arbitration stage
// and one AHB-Lite slave.
//   mst_* : one request lane per master port, plus the shared return path
//           (mst_HRDATA/mst_HREADYOUT/mst_HRESP) and the one-hot master_granted.
//   slv_* : the single AHB-Lite slave connection.
// Modports:
//   slave  - the arbitration stage (consumes lanes, drives the slave)
//   master - the environment side (drives lanes, models the slave)
interface peripheral_msi_slave_port_apb4_if #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
);
    logic [MASTERS-1:0][2:0]      mst_priority;
    logic [MASTERS-1:0]           mst_HSEL;
    logic [MASTERS-1:0][PLEN-1:0] mst_HADDR;
    logic [MASTERS-1:0][XLEN-1:0] mst_HWDATA;
    logic [MASTERS-1:0]           mst_HWRITE;
    logic [MASTERS-1:0][2:0]      mst_HSIZE;
    logic [MASTERS-1:0][2:0]      mst_HBURST;
    logic [MASTERS-1:0][3:0]      mst_HPROT;
    logic [MASTERS-1:0][1:0]      mst_HTRANS;
    logic [MASTERS-1:0]           mst_HMASTLOCK;
    logic [MASTERS-1:0]           mst_HREADY;
    logic [MASTERS-1:0]           mst_can_switch;
    logic [MASTERS-1:0]           master_granted;
    logic [XLEN-1:0]              mst_HRDATA;
    logic                         mst_HREADYOUT;
    logic                         mst_HRESP;

    logic                         slv_HSEL;
    logic [PLEN-1:0]              slv_HADDR;
    logic [XLEN-1:0]              slv_HWDATA;
    logic                         slv_HWRITE;
    logic [2:0]                   slv_HSIZE;
    logic [2:0]                   slv_HBURST;
    logic [3:0]                   slv_HPROT;
    logic [1:0]                   slv_HTRANS;
    logic                         slv_HMASTLOCK;
    logic                         slv_HREADY;
    logic [XLEN-1:0]              slv_HRDATA;
    logic                         slv_HREADYOUT;
    logic                         slv_HRESP;

    modport slave (
        input  mst_priority, mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE,
               mst_HSIZE, mst_HBURST, mst_HPROT, mst_HTRANS, mst_HMASTLOCK,
               mst_HREADY, mst_can_switch,
        output master_granted, mst_HRDATA, mst_HREADYOUT, mst_HRESP,
        output slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE,
               slv_HBURST, slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADY,
        input  slv_HRDATA, slv_HREADYOUT, slv_HRESP
    );

    modport master (
        output mst_priority, mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE,
               mst_HSIZE, mst_HBURST, mst_HPROT, mst_HTRANS, mst_HMASTLOCK,
               mst_HREADY, mst_can_switch,
        input  master_granted, mst_HRDATA, mst_HREADYOUT, mst_HRESP,
        input  slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE,
               slv_HBURST, slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADY,
        output slv_HRDATA, slv_HREADYOUT, slv_HRESP
    );
endinterface

// File: rtl/peripheral_msi_slave_port_apb4.sv
// Per-slave arbitration and multiplexing stage of the MSI interconnect.
// Picks one owning master lane (highest priority, round-robin among ties),
// forwards its address phase to the slave, and routes HWDATA by a separately
// tracked data-phase owner so write data stays correct across switches.
// Ports:
//   HCLK   - clock, all state on rising edge
//   HRESET - synchronous active-high reset
//   bus    - lane/slave bundle (slave modport); its parameters must match
//            PLEN/XLEN/MASTERS given here
module peripheral_msi_slave_port_apb4 #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
) (
    input logic HCLK,
    input logic HRESET,
    peripheral_msi_slave_port_apb4_if.slave bus
);
    localparam int MASTERS_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic [MASTERS-1:0] GRANT_LSB = MASTERS'(1);

    logic                    owner_valid;
    logic [MASTERS_BITS-1:0] owner;
    logic                    data_valid;
    logic [MASTERS_BITS-1:0] data_owner;
    logic [MASTERS_BITS-1:0] last_grant;
    logic [MASTERS-1:0]      grant;

    logic                    any_req;
    logic [MASTERS_BITS-1:0] winner;
    logic [2:0]              best_prio;
    logic [MASTERS_BITS-1:0] idx;
    logic                    arb_en;
    logic                    data_adv;
    logic                    sel;
    logic                    ready_to_slave;

    // Scan starts just after the last grant; a strict '>' keeps the first
    // tied lane in scan order, which gives round-robin among equal priorities.
    always_comb begin
        any_req   = 1'b0;
        winner    = '0;
        best_prio = '0;
        idx       = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = MASTERS_BITS'((int'(last_grant) + k) % MASTERS);
            if (bus.mst_HSEL[idx] && (!any_req || bus.mst_priority[idx] > best_prio)) begin
                any_req   = 1'b1;
                winner    = idx;
                best_prio = bus.mst_priority[idx];
            end
        end
    end

    // Ownership may only move on a slave-ready cycle of an unlocked owner
    // that allows it, so the outgoing data phase always completes cleanly.
    assign arb_en = !owner_valid ||
                    (bus.mst_can_switch[owner] && !bus.mst_HMASTLOCK[owner] && bus.slv_HREADYOUT);

    assign sel            = owner_valid & bus.mst_HSEL[owner];
    assign ready_to_slave = owner_valid ? bus.mst_HREADY[owner] : 1'b1;
    assign data_adv       = bus.slv_HREADYOUT & ready_to_slave;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner_valid <= 1'b0;
            data_valid  <= 1'b0;
            last_grant  <= MASTERS_BITS'(MASTERS - 1);
            grant       <= '0;
        end else begin
            if (arb_en) begin
                if (any_req) begin
                    owner       <= winner;
                    owner_valid <= 1'b1;
                    last_grant  <= winner;
                    grant       <= GRANT_LSB << winner;
                end else begin
                    owner_valid <= 1'b0;
                    grant       <= '0;
                end
            end
            // The address phase accepted this edge becomes the data phase.
            if (data_adv) begin
                data_valid <= sel &&
                              (bus.mst_HTRANS[owner] == HTRANS_NONSEQ ||
                               bus.mst_HTRANS[owner] == HTRANS_SEQ);
                data_owner <= owner;
            end
        end
    end

    assign bus.master_granted = grant;

    assign bus.slv_HSEL      = sel;
    assign bus.slv_HTRANS    = sel ? bus.mst_HTRANS[owner] : HTRANS_IDLE;
    assign bus.slv_HADDR     = owner_valid ? bus.mst_HADDR[owner]     : '0;
    assign bus.slv_HWRITE    = owner_valid ? bus.mst_HWRITE[owner]    : 1'b0;
    assign bus.slv_HSIZE     = owner_valid ? bus.mst_HSIZE[owner]     : 3'b000;
    assign bus.slv_HBURST    = owner_valid ? bus.mst_HBURST[owner]    : 3'b000;
    assign bus.slv_HPROT     = owner_valid ? bus.mst_HPROT[owner]     : 4'b0000;
    assign bus.slv_HMASTLOCK = owner_valid ? bus.mst_HMASTLOCK[owner] : 1'b0;
    assign bus.slv_HREADY    = ready_to_slave;

    // Write data belongs to the data-phase owner, which lags owner by one
    // accepted transfer across a switch.
    assign bus.slv_HWDATA    = bus.mst_HWDATA[data_owner];

    assign bus.mst_HRDATA    = bus.slv_HRDATA;
    assign bus.mst_HREADYOUT = bus.slv_HREADYOUT;
    assign bus.mst_HRESP     = data_valid ? bus.slv_HRESP : HRESP_OKAY;
endmodule

// File: tb/tb_peripheral_msi_slave_port_apb4.sv
module tb_peripheral_msi_slave_port_apb4;
    localparam int PLEN    = 64;
    localparam int XLEN    = 64;
    localparam int MASTERS = 5;

    logic HCLK;
    logic HRESET;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    peripheral_msi_slave_port_apb4_if #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(MASTERS)) bus ();

    peripheral_msi_slave_port_apb4 #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(MASTERS)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic clr();
        bus.mst_priority   = '0;
        bus.mst_HSEL       = '0;
        bus.mst_HADDR      = '0;
        bus.mst_HWDATA     = '0;
        bus.mst_HWRITE     = '0;
        bus.mst_HSIZE      = '0;
        bus.mst_HBURST     = '0;
        bus.mst_HPROT      = '0;
        bus.mst_HTRANS     = '0;
        bus.mst_HMASTLOCK  = '0;
        bus.mst_HREADY     = '1;
        bus.mst_can_switch = '0;
        bus.slv_HRDATA     = 64'h0;
        bus.slv_HREADYOUT  = 1'b1;
        bus.slv_HRESP      = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
    endtask

    logic [4:0] rr_exp [6];

    initial begin
        rr_exp = '{5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100, 5'b10000};
        HRESET = 1'b1;
        clr();
        tick();

        // Reset state
        do_reset();
        chk("rst_grant",     64'(bus.master_granted), 64'h0);
        chk("rst_hsel",      64'(bus.slv_HSEL),       64'h0);
        chk("rst_htrans",    64'(bus.slv_HTRANS),     64'h0);
        chk("rst_hready",    64'(bus.slv_HREADY),     64'h1);
        chk("rst_hreadyout", 64'(bus.mst_HREADYOUT),  64'h1);
        chk("rst_hresp",     64'(bus.mst_HRESP),      64'h0);

        // Single request on lane 2: pending one cycle, then granted
        bus.mst_HSEL[2]     = 1'b1;
        bus.mst_priority[2] = 3'd1;
        bus.mst_HADDR[2]    = 64'h0000_0000_0000_2000;
        bus.mst_HTRANS[2]   = 2'b10;
        #1;
        chk("single_pending", 64'(bus.master_granted), 64'h0);
        chk("single_pend_sel", 64'(bus.slv_HSEL), 64'h0);
        tick();
        chk("single_grant",  64'(bus.master_granted), 64'h04);
        chk("single_hsel",   64'(bus.slv_HSEL),       64'h1);
        chk("single_haddr",  bus.slv_HADDR,           64'h2000);
        chk("single_htrans", 64'(bus.slv_HTRANS),     64'h2);

        // Priority: lane 3 (5) beats lane 0 (2); lane 0 follows once lane 3 lets go
        do_reset();
        bus.mst_HSEL[0] = 1'b1; bus.mst_priority[0] = 3'd2;
        bus.mst_HSEL[3] = 1'b1; bus.mst_priority[3] = 3'd5;
        tick();
        chk("prio_win",  64'(bus.master_granted), 64'h08);
        tick();
        chk("prio_hold", 64'(bus.master_granted), 64'h08);
        bus.mst_HSEL[3] = 1'b0;
        bus.mst_can_switch[3] = 1'b1;
        tick();
        chk("prio_switch", 64'(bus.master_granted), 64'h01);

        // Equal-priority round robin over lanes 1, 2, 4
        do_reset();
        for (int i = 0; i < MASTERS; i++) bus.mst_can_switch[i] = 1'b1;
        bus.mst_HSEL[1] = 1'b1; bus.mst_priority[1] = 3'd3;
        bus.mst_HSEL[2] = 1'b1; bus.mst_priority[2] = 3'd3;
        bus.mst_HSEL[4] = 1'b1; bus.mst_priority[4] = 3'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_%0d", i), 64'(bus.master_granted), 64'(rr_exp[i]));
        end

        // Locked owner keeps the grant against a higher-priority requester
        do_reset();
        bus.mst_HSEL[1] = 1'b1; bus.mst_priority[1] = 3'd1;
        bus.mst_can_switch[1] = 1'b1; bus.mst_HMASTLOCK[1] = 1'b1;
        tick();
        chk("lock_grant", 64'(bus.master_granted), 64'h02);
        bus.mst_HSEL[0] = 1'b1; bus.mst_priority[0] = 3'd7;
        tick();
        chk("lock_hold1", 64'(bus.master_granted), 64'h02);
        chk("lock_mlock", 64'(bus.slv_HMASTLOCK),  64'h1);
        tick();
        chk("lock_hold2", 64'(bus.master_granted), 64'h02);
        bus.mst_HMASTLOCK[1] = 1'b0;
        tick();
        chk("lock_release", 64'(bus.master_granted), 64'h01);

        // Write from lane 0, switch to lane 3, slave stalls two cycles
        do_reset();
        bus.mst_HSEL[0] = 1'b1; bus.mst_priority[0] = 3'd1;
        bus.mst_HTRANS[0] = 2'b10; bus.mst_HWRITE[0] = 1'b1;
        bus.mst_HADDR[0] = 64'h100; bus.mst_HWDATA[0] = 64'hA0A0_A0A0;
        bus.mst_HWDATA[3] = 64'hD3D3_D3D3;
        tick();
        chk("wr_grant0", 64'(bus.master_granted), 64'h01);
        chk("wr_hwrite", 64'(bus.slv_HWRITE),     64'h1);
        chk("wr_haddr0", bus.slv_HADDR,           64'h100);
        bus.mst_HSEL[3] = 1'b1; bus.mst_priority[3] = 3'd1;
        bus.mst_HTRANS[3] = 2'b10; bus.mst_HWRITE[3] = 1'b1;
        bus.mst_HADDR[3] = 64'h300;
        bus.mst_can_switch[0] = 1'b1;
        tick();
        chk("wr_grant3",  64'(bus.master_granted), 64'h08);
        chk("wr_hwdata0", bus.slv_HWDATA,          64'hA0A0_A0A0);
        chk("wr_haddr3",  bus.slv_HADDR,           64'h300);
        bus.slv_HREADYOUT = 1'b0;
        bus.slv_HRESP     = 1'b1;
        bus.mst_can_switch[3] = 1'b1;
        #1;
        chk("wr_readyout_fwd", 64'(bus.mst_HREADYOUT), 64'h0);
        chk("wr_hresp_fwd",    64'(bus.mst_HRESP),     64'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("stall_grant_%0d", i),  64'(bus.master_granted), 64'h08);
            chk($sformatf("stall_hwdata_%0d", i), bus.slv_HWDATA,          64'hA0A0_A0A0);
            chk($sformatf("stall_haddr_%0d", i),  bus.slv_HADDR,           64'h300);
        end
        bus.slv_HREADYOUT = 1'b1;
        bus.slv_HRESP     = 1'b0;
        tick();
        chk("post_stall_grant",  64'(bus.master_granted), 64'h01);
        chk("post_stall_hwdata", bus.slv_HWDATA,          64'hD3D3_D3D3);

        // Reset in the middle of a lane 2 burst
        do_reset();
        bus.mst_HSEL[2] = 1'b1; bus.mst_priority[2] = 3'd1;
        bus.mst_HTRANS[2] = 2'b10;
        tick();
        chk("burst_grant", 64'(bus.master_granted), 64'h04);
        bus.mst_HTRANS[2] = 2'b11;
        tick();
        bus.slv_HRESP = 1'b1;
        #1;
        chk("burst_hresp", 64'(bus.mst_HRESP), 64'h1);
        HRESET = 1'b1;
        bus.mst_HSEL[0] = 1'b1; bus.mst_priority[0] = 3'd1;
        for (int i = 0; i < MASTERS; i++) bus.mst_can_switch[i] = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        chk("mid_rst_grant",  64'(bus.master_granted), 64'h0);
        chk("mid_rst_htrans", 64'(bus.slv_HTRANS),     64'h0);
        chk("mid_rst_hresp",  64'(bus.mst_HRESP),      64'h0);
        tick();
        chk("mid_rst_rr0", 64'(bus.master_granted), 64'h01);
        tick();
        chk("mid_rst_rr2", 64'(bus.master_granted), 64'h04);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
